stopwatch_ctrl: RTL and testbench

Controller that sequences a BCD mm:ss mod-60/mod-60 counter chain as a stopwatch. Prescales the system clock into a 1 s tick and runs a start/stop/clear/lap state machine. Owns the seconds and minutes BCD counters and gates their enable. Sits between debounced panel buttons and the 7-segment display driver.

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/bcd60_cell.sv | 41 ++++
 rtl/stopwatch_ctrl.sv | 141 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and BCD limits for the mm:ss stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0]  BCD_ONES_MAX = 4'd9;
    localparam logic [3:0]  BCD_TENS_MAX = 4'd5;
    localparam logic [15:0] BCD_MAX_MMSS = 16'h5959;

endpackage

// File: rtl/bcd60_cell.sv
// Two-digit BCD counter 00..59 with synchronous clear (priority) and count enable.
module bcd60_cell
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic       clr,
    output logic [7:0] bcd,
    output logic       carry
);

    logic [3:0] r_ones;
    logic [3:0] r_tens;
    logic       w_ones_wrap;
    logic       w_tens_wrap;

    assign w_ones_wrap = (r_ones == BCD_ONES_MAX);
    assign w_tens_wrap = (r_tens == BCD_TENS_MAX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ones <= 4'd0;
            r_tens <= 4'd0;
        end else if (clr) begin
            r_ones <= 4'd0;
            r_tens <= 4'd0;
        end else if (en) begin
            if (w_ones_wrap) begin
                r_ones <= 4'd0;
                r_tens <= w_tens_wrap ? 4'd0 : r_tens + 4'd1;
            end else begin
                r_ones <= r_ones + 4'd1;
            end
        end
    end

    assign bcd   = {r_tens, r_ones};
    assign carry = en & w_ones_wrap & w_tens_wrap;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button edge detect, run/pause/done FSM, 1 s prescaler,
// lap capture, and the seconds/minutes BCD counter chain.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        btn_start,
    input  logic        btn_stop,
    input  logic        btn_clear,
    input  logic        btn_lap,
    output logic [7:0]  sec_bcd,
    output logic [7:0]  min_bcd,
    output logic [15:0] lap_bcd,
    output logic        lap_valid,
    output logic        sec_tick,
    output logic        running,
    output logic        done
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [PW-1:0] r_presc;
    logic [3:0]    r_btn_q;
    logic [15:0]   r_lap;
    logic          r_lap_valid;
    logic          r_sec_tick;
    logic          r_running;
    logic          r_done;

    logic [3:0]    w_btn;
    logic [3:0]    w_rise;
    logic          w_clr_fire;
    logic          w_stop_fire;
    logic          w_start_fire;
    logic          w_lap_fire;
    logic          w_tick;
    logic          w_at_max;
    logic          w_sec_en;
    logic          w_sec_carry;
    logic          w_min_carry;
    logic [7:0]    w_sec;
    logic [7:0]    w_min;

    assign w_btn  = {btn_lap, btn_clear, btn_stop, btn_start};
    assign w_rise = w_btn & ~r_btn_q;

    // Clear masks everything; stop masks start; lap only yields to clear.
    assign w_clr_fire   = w_rise[2];
    assign w_stop_fire  = w_rise[1] & ~w_clr_fire;
    assign w_start_fire = w_rise[0] & ~w_clr_fire & ~w_rise[1];
    assign w_lap_fire   = w_rise[3] & ~w_clr_fire;

    assign w_tick   = (r_state == ST_RUN) && (r_presc == PRESC_LAST);
    assign w_at_max = ({w_min, w_sec} == BCD_MAX_MMSS);
    assign w_sec_en = w_tick & ~w_at_max;

    bcd60_cell u_sec (
        .clk   (clk),
        .rstn  (rstn),
        .en    (w_sec_en),
        .clr   (w_clr_fire),
        .bcd   (w_sec),
        .carry (w_sec_carry)
    );

    bcd60_cell u_min (
        .clk   (clk),
        .rstn  (rstn),
        .en    (w_sec_carry),
        .clr   (w_clr_fire),
        .bcd   (w_min),
        .carry (w_min_carry)
    );

    always_comb begin
        w_state_next = r_state;
        if (w_clr_fire) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_start_fire) w_state_next = ST_RUN;
                ST_RUN: begin
                    if (w_tick && w_at_max) w_state_next = ST_DONE;
                    else if (w_stop_fire)   w_state_next = ST_PAUSE;
                end
                ST_PAUSE: if (w_start_fire) w_state_next = ST_RUN;
                default:  w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_presc     <= '0;
            r_btn_q     <= 4'd0;
            r_lap       <= 16'd0;
            r_lap_valid <= 1'b0;
            r_sec_tick  <= 1'b0;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_btn_q    <= w_btn;
            r_state    <= w_state_next;
            r_running  <= (w_state_next == ST_RUN);
            r_done     <= (w_state_next == ST_DONE);
            r_sec_tick <= w_tick & ~w_clr_fire;

            // The prescaler freezes outside RUN so a pause keeps the partial second.
            if (w_clr_fire)
                r_presc <= '0;
            else if (r_state == ST_RUN)
                r_presc <= w_tick ? '0 : r_presc + PW'(1);

            if (w_clr_fire) begin
                r_lap       <= 16'd0;
                r_lap_valid <= 1'b0;
            end else if (w_lap_fire && (r_state == ST_RUN || r_state == ST_PAUSE)) begin
                r_lap       <= {w_min, w_sec};
                r_lap_valid <= 1'b1;
            end else begin
                r_lap_valid <= 1'b0;
            end
        end
    end

    assign sec_bcd   = w_sec;
    assign min_bcd   = w_min;
    assign lap_bcd   = r_lap;
    assign lap_valid = r_lap_valid;
    assign sec_tick  = r_sec_tick;
    assign running   = r_running;
    assign done      = r_done;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4: a per-cycle vector table
// followed by hand-written multi-cycle sequences.
module tb_stopwatch_ctrl;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        bs = 1'b0, bp = 1'b0, bc = 1'b0, bl = 1'b0;
    logic [7:0]  sec_bcd, min_bcd;
    logic [15:0] lap_bcd;
    logic        lap_valid, sec_tick, running, done;

    int n_vec = 0;
    int n_bad = 0;

    stopwatch_ctrl #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .btn_start (bs),
        .btn_stop  (bp),
        .btn_clear (bc),
        .btn_lap   (bl),
        .sec_bcd   (sec_bcd),
        .min_bcd   (min_bcd),
        .lap_bcd   (lap_bcd),
        .lap_valid (lap_valid),
        .sec_tick  (sec_tick),
        .running   (running),
        .done      (done)
    );

    always #5 clk = ~clk;

    // btn order: {lap, clear, stop, start}
    typedef struct {
        logic [3:0]  btn;
        logic [7:0]  sec;
        logic [7:0]  mn;
        logic [15:0] lap;
        logic        lv;
        logic        tk;
        logic        run;
        logic        dn;
    } vec_t;

    vec_t vt[16];

    function automatic vec_t mk(input logic [3:0] b, input logic [7:0] s, input logic [7:0] m,
                                input logic [15:0] l, input logic lv, input logic tk,
                                input logic run, input logic dn);
        vec_t v;
        v.btn = b; v.sec = s; v.mn = m; v.lap = l;
        v.lv = lv; v.tk = tk; v.run = run; v.dn = dn;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] b);
        @(negedge clk);
        {bl, bc, bp, bs} = b;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int maxc, output int n);
        n = 0;
        do begin
            cyc(4'b0000);
            n++;
        end while (sec_tick !== 1'b1 && n < maxc);
        if (sec_tick !== 1'b1) begin
            n_vec++;
            n_bad++;
            $display("FAIL tick_timeout: got no sec_tick within %0d cycles, expected one", maxc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1 ms, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, errs;
        logic [7:0] s0, m0;

        vt[0]  = mk(4'b0000, 8'h00, 8'h00, 16'h0000, 0, 0, 0, 0);
        vt[1]  = mk(4'b0001, 8'h00, 8'h00, 16'h0000, 0, 0, 1, 0);
        vt[2]  = mk(4'b0000, 8'h00, 8'h00, 16'h0000, 0, 0, 1, 0);
        vt[3]  = mk(4'b0000, 8'h00, 8'h00, 16'h0000, 0, 0, 1, 0);
        vt[4]  = mk(4'b1000, 8'h00, 8'h00, 16'h0000, 1, 0, 1, 0);
        vt[5]  = mk(4'b0000, 8'h01, 8'h00, 16'h0000, 0, 1, 1, 0);
        vt[6]  = mk(4'b0000, 8'h01, 8'h00, 16'h0000, 0, 0, 1, 0);
        vt[7]  = mk(4'b0010, 8'h01, 8'h00, 16'h0000, 0, 0, 0, 0);
        vt[8]  = mk(4'b1000, 8'h01, 8'h00, 16'h0001, 1, 0, 0, 0);
        vt[9]  = mk(4'b0000, 8'h01, 8'h00, 16'h0001, 0, 0, 0, 0);
        vt[10] = mk(4'b0001, 8'h01, 8'h00, 16'h0001, 0, 0, 1, 0);
        vt[11] = mk(4'b0000, 8'h01, 8'h00, 16'h0001, 0, 0, 1, 0);
        vt[12] = mk(4'b0000, 8'h02, 8'h00, 16'h0001, 0, 1, 1, 0);
        vt[13] = mk(4'b1100, 8'h00, 8'h00, 16'h0000, 0, 0, 0, 0);
        vt[14] = mk(4'b0010, 8'h00, 8'h00, 16'h0000, 0, 0, 0, 0);
        vt[15] = mk(4'b0100, 8'h00, 8'h00, 16'h0000, 0, 0, 0, 0);

        // Reset state
        #12;
        chk("reset_sec", sec_bcd, 8'h00);
        chk("reset_running", running, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            cyc(vt[i].btn);
            chk($sformatf("v%0d_sec", i), sec_bcd, vt[i].sec);
            chk($sformatf("v%0d_min", i), min_bcd, vt[i].mn);
            chk($sformatf("v%0d_lap", i), lap_bcd, vt[i].lap);
            chk($sformatf("v%0d_lap_valid", i), lap_valid, vt[i].lv);
            chk($sformatf("v%0d_sec_tick", i), sec_tick, vt[i].tk);
            chk($sformatf("v%0d_running", i), running, vt[i].run);
            chk($sformatf("v%0d_done", i), done, vt[i].dn);
        end

        // Tick cadence and seconds -> minutes carry
        cyc(4'b0001);
        chk("start_running", running, 1'b1);
        wait_tick(8, n);
        chk("first_tick_latency", n, 4);
        errs = 0;
        for (int i = 0; i < 9; i++) begin
            wait_tick(8, n);
            if (n != 4) errs++;
        end
        chk("tick_spacing", errs, 0);
        chk("ten_sec", sec_bcd, 8'h10);
        chk("ten_min", min_bcd, 8'h00);
        for (int i = 0; i < 49; i++) wait_tick(8, n);
        chk("at_059_sec", sec_bcd, 8'h59);
        chk("at_059_min", min_bcd, 8'h00);
        wait_tick(8, n);
        chk("carry_sec", sec_bcd, 8'h00);
        chk("carry_min", min_bcd, 8'h01);
        chk("carry_tick", sec_tick, 1'b1);

        // Pause 2 cycles into a second, resume preserves the partial second
        cyc(4'b0000);
        cyc(4'b0010);
        chk("pause_running", running, 1'b0);
        s0 = sec_bcd;
        m0 = min_bcd;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(4'b0000);
            if (sec_bcd !== s0 || min_bcd !== m0 || sec_tick !== 1'b0) errs++;
        end
        chk("pause_hold", errs, 0);
        cyc(4'b0001);
        chk("resume_running", running, 1'b1);
        chk("resume_tick0", sec_tick, 1'b0);
        cyc(4'b0000);
        chk("resume_tick1", sec_tick, 1'b0);
        cyc(4'b0000);
        chk("resume_tick2", sec_tick, 1'b1);
        chk("resume_sec", sec_bcd, 8'h01);
        chk("resume_min", min_bcd, 8'h01);

        // Full run to 59:59 and DONE
        cyc(4'b0100);
        chk("clr_sec", sec_bcd, 8'h00);
        chk("clr_min", min_bcd, 8'h00);
        cyc(4'b0001);
        for (int i = 0; i < 3599; i++) wait_tick(6, n);
        chk("max_sec", sec_bcd, 8'h59);
        chk("max_min", min_bcd, 8'h59);
        chk("max_running", running, 1'b1);
        chk("max_done", done, 1'b0);
        wait_tick(6, n);
        chk("done_flag", done, 1'b1);
        chk("done_running", running, 1'b0);
        chk("done_sec", sec_bcd, 8'h59);
        chk("done_min", min_bcd, 8'h59);
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(4'b0000);
            if (sec_tick !== 1'b0 || sec_bcd !== 8'h59 || min_bcd !== 8'h59) errs++;
        end
        chk("done_hold", errs, 0);
        cyc(4'b0001);
        chk("done_start_ign", done, 1'b1);
        chk("done_start_run", running, 1'b0);
        cyc(4'b0000);
        cyc(4'b0100);
        chk("done_clr_done", done, 1'b0);
        chk("done_clr_sec", sec_bcd, 8'h00);
        chk("done_clr_min", min_bcd, 8'h00);
        chk("done_clr_run", running, 1'b0);

        // clear + start in PAUSE
        cyc(4'b0001);
        cyc(4'b0000);
        cyc(4'b0000);
        cyc(4'b0010);
        chk("p_running", running, 1'b0);
        cyc(4'b0000);
        cyc(4'b0101);
        chk("clrstart_running", running, 1'b0);
        chk("clrstart_sec", sec_bcd, 8'h00);
        chk("clrstart_lap", lap_bcd, 16'h0000);
        cyc(4'b0000);
        chk("clrstart_idle", running, 1'b0);

        // Lap coinciding with the tick at 00:09
        cyc(4'b0001);
        for (int i = 0; i < 9; i++) wait_tick(8, n);
        chk("pre_lap_sec", sec_bcd, 8'h09);
        cyc(4'b0000);
        cyc(4'b0000);
        cyc(4'b0000);
        cyc(4'b1000);
        chk("lap_tick_lap", lap_bcd, 16'h0009);
        chk("lap_tick_sec", sec_bcd, 8'h10);
        chk("lap_tick_valid", lap_valid, 1'b1);
        chk("lap_tick_tick", sec_tick, 1'b1);
        cyc(4'b0000);
        chk("lap_valid_drop", lap_valid, 1'b0);
        chk("lap_hold", lap_bcd, 16'h0009);

        // Held start acts once: a stop while it is held must stick
        cyc(4'b0100);
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            cyc((i == 2) ? 4'b0011 : 4'b0001);
            if (i == 0 && running !== 1'b1) errs++;
            if (i >= 2 && running !== 1'b0) errs++;
        end
        chk("held_start", errs, 0);
        cyc(4'b0000);

        // Asynchronous reset mid-run
        cyc(4'b0100);
        cyc(4'b0001);
        wait_tick(8, n);
        wait_tick(8, n);
        cyc(4'b1000);
        chk("prerst_sec", sec_bcd, 8'h02);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_sec", sec_bcd, 8'h00);
        chk("arst_min", min_bcd, 8'h00);
        chk("arst_lap", lap_bcd, 16'h0000);
        chk("arst_lv", lap_valid, 1'b0);
        chk("arst_tick", sec_tick, 1'b0);
        chk("arst_running", running, 1'b0);
        chk("arst_done", done, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        errs = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(4'b0000);
            if (running !== 1'b0 || sec_bcd !== 8'h00 || sec_tick !== 1'b0) errs++;
        end
        chk("postrst_idle", errs, 0);
        cyc(4'b0001);
        chk("postrst_start", running, 1'b1);
        wait_tick(8, n);
        chk("postrst_latency", n, 4);
        chk("postrst_sec", sec_bcd, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
